// File: rtl/pc_sequencer_if.sv
// Fetch/issue bundle for pc_sequencer: control, instruction-memory port and
// decode-side issue port. The master modport is the sequencer side.
interface pc_sequencer_if;
    logic        start;
    logic        imem_req;
    logic [9:0]  imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        inst_valid;
    logic [31:0] inst;
    logic [9:0]  inst_pc;
    logic        dec_ready;
    logic        redirect;
    logic [9:0]  redirect_pc;
    logic        halt_req;
    logic [9:0]  pc;
    logic        misalign;
    logic        busy;

    modport master (
        input  start, imem_ack, imem_rdata, dec_ready, redirect, redirect_pc, halt_req,
        output imem_req, imem_addr, inst_valid, inst, inst_pc, pc, misalign, busy
    );

    modport slave (
        output start, imem_ack, imem_rdata, dec_ready, redirect, redirect_pc, halt_req,
        input  imem_req, imem_addr, inst_valid, inst, inst_pc, pc, misalign, busy
    );
endinterface

// File: rtl/pc_sequencer.sv
// Program-counter sequencer: fetches one instruction at a time, hands it to
// decode, and follows redirects (with misaligned-target trapping) and halts.
module pc_sequencer #(
    parameter logic [9:0] RESET_PC = 10'h000,
    parameter logic [9:0] TRAP_VEC = 10'h3F0
) (
    input logic           clk,
    input logic           rst,
    pc_sequencer_if.master bus
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_FETCH,
        S_ISSUE,
        S_HALT
    } state_t;

    state_t      r_state, w_state_nxt;
    logic [9:0]  r_pc, w_pc_nxt;
    logic [31:0] r_inst, w_inst_nxt;
    logic [9:0]  r_inst_pc, w_inst_pc_nxt;
    logic        r_misalign, w_misalign_nxt;
    logic        r_halt_pend, w_halt_pend_nxt;
    logic        r_redir_pend, w_redir_pend_nxt;
    logic [9:0]  r_redir_pc, w_redir_pc_nxt;

    logic [9:0]  w_tgt_raw;
    logic        w_tgt_bad;
    logic [9:0]  w_tgt;
    logic        w_halt;

    // A same-cycle redirect supersedes any target already waiting for the ack.
    assign w_tgt_raw = bus.redirect ? bus.redirect_pc : r_redir_pc;
    assign w_tgt_bad = |w_tgt_raw[1:0];
    assign w_tgt     = w_tgt_bad ? TRAP_VEC : w_tgt_raw;
    assign w_halt    = r_halt_pend | bus.halt_req;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_pc         <= RESET_PC;
            r_inst       <= '0;
            r_inst_pc    <= '0;
            r_misalign   <= 1'b0;
            r_halt_pend  <= 1'b0;
            r_redir_pend <= 1'b0;
            r_redir_pc   <= '0;
        end else begin
            r_state      <= w_state_nxt;
            r_pc         <= w_pc_nxt;
            r_inst       <= w_inst_nxt;
            r_inst_pc    <= w_inst_pc_nxt;
            r_misalign   <= w_misalign_nxt;
            r_halt_pend  <= w_halt_pend_nxt;
            r_redir_pend <= w_redir_pend_nxt;
            r_redir_pc   <= w_redir_pc_nxt;
        end
    end

    always_comb begin
        w_state_nxt      = r_state;
        w_pc_nxt         = r_pc;
        w_inst_nxt       = r_inst;
        w_inst_pc_nxt    = r_inst_pc;
        w_misalign_nxt   = r_misalign;
        w_halt_pend_nxt  = r_halt_pend;
        w_redir_pend_nxt = r_redir_pend;
        w_redir_pc_nxt   = r_redir_pc;

        unique case (r_state)
            S_IDLE: begin
                if (bus.start) w_state_nxt = S_FETCH;
            end
            S_FETCH: begin
                if (bus.halt_req) w_halt_pend_nxt = 1'b1;
                if (bus.imem_ack) begin
                    if (bus.redirect || r_redir_pend) begin
                        // Returned word belongs to the abandoned path; drop it.
                        w_pc_nxt         = w_tgt;
                        w_misalign_nxt   = r_misalign | w_tgt_bad;
                        w_redir_pend_nxt = 1'b0;
                    end else begin
                        w_inst_nxt    = bus.imem_rdata;
                        w_inst_pc_nxt = r_pc;
                        w_pc_nxt      = r_pc + 10'd4;
                        w_state_nxt   = S_ISSUE;
                    end
                end else if (bus.redirect) begin
                    // Address must hold until the outstanding request completes.
                    w_redir_pend_nxt = 1'b1;
                    w_redir_pc_nxt   = bus.redirect_pc;
                end
            end
            S_ISSUE: begin
                if (bus.halt_req) w_halt_pend_nxt = 1'b1;
                if (bus.dec_ready && w_halt) begin
                    w_state_nxt = S_HALT;
                end else if (bus.redirect) begin
                    w_pc_nxt       = w_tgt;
                    w_misalign_nxt = r_misalign | w_tgt_bad;
                    w_state_nxt    = S_FETCH;
                end else if (bus.dec_ready) begin
                    w_state_nxt = S_FETCH;
                end
            end
            S_HALT: begin
                w_state_nxt = S_HALT;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    assign bus.imem_req   = (r_state == S_FETCH);
    assign bus.imem_addr  = r_pc;
    assign bus.inst_valid = (r_state == S_ISSUE);
    assign bus.inst       = r_inst;
    assign bus.inst_pc    = r_inst_pc;
    assign bus.pc         = r_pc;
    assign bus.misalign   = r_misalign;
    assign bus.busy       = (r_state == S_FETCH) || (r_state == S_ISSUE);

    // Handshake stability on both memory and decode sides.
    property p_fetch_addr_hold;
        @(posedge clk) disable iff (rst)
            (bus.imem_req && !bus.imem_ack) |=> (bus.imem_req && $stable(bus.imem_addr));
    endproperty
    a_fetch_addr_hold: assert property (p_fetch_addr_hold);

    property p_issue_hold;
        @(posedge clk) disable iff (rst)
            (bus.inst_valid && !bus.dec_ready && !bus.redirect)
                |=> (bus.inst_valid && $stable(bus.inst) && $stable(bus.inst_pc));
    endproperty
    a_issue_hold: assert property (p_issue_hold);

endmodule

// File: doc/pc_sequencer.md
PC_SEQUENCER -- requirements
Module: pc_sequencer

Interface
REQ-001 Parameter RESET_PC, default 10'h000, SHALL be the PC value loaded at reset.
REQ-002 Parameter TRAP_VEC, default 10'h3F0, SHALL be the PC loaded on a misaligned redirect.
REQ-003 clk  in  1  SHALL be the clock; all state updates on its rising edge.
REQ-004 rst  in  1  SHALL be a synchronous, active-high reset.
REQ-005 start  in  1  SHALL leave IDLE and begin fetching.
REQ-006 imem_req  out  1  SHALL be the instruction-memory request.
REQ-007 imem_addr  out  10  SHALL be the fetch byte address, always equal to pc.
REQ-008 imem_ack  in  1  SHALL indicate imem_rdata is valid for the outstanding request.
REQ-009 imem_rdata  in  32  SHALL carry the fetched instruction.
REQ-010 inst_valid  out  1  SHALL mark inst/inst_pc as valid toward decode.
REQ-011 inst  out  32, inst_pc  out  10  SHALL be the issued instruction and its address.
REQ-012 dec_ready  in  1  SHALL indicate decode accepts inst this cycle.
REQ-013 redirect  in  1, redirect_pc  in  10  SHALL request a branch/jump to redirect_pc.
REQ-014 halt_req  in  1  SHALL request a stop at the next instruction boundary.
REQ-015 pc  out  10  SHALL be the current fetch PC.
REQ-016 misalign  out  1 (sticky), busy  out  1  SHALL flag a misaligned target and non-IDLE/non-HALT state respectively.

Function
REQ-017 FSM states SHALL be IDLE, FETCH, ISSUE, HALT, one-hot or binary.
REQ-018 IDLE: imem_req=0, inst_valid=0; start=1 -> FETCH next cycle; otherwise stay.
REQ-019 FETCH: imem_req=1; imem_addr SHALL stay constant until imem_ack.
REQ-020 FETCH with imem_ack, no pending/same-cycle redirect: inst<=imem_rdata, inst_pc<=pc, pc<=pc+4, -> ISSUE (1-cycle latency ack-to-inst_valid).
REQ-021 PC arithmetic SHALL be modulo 1024: 10'h3FC+4 -> 10'h000.
REQ-022 ISSUE: inst_valid=1, imem_req=0; inst/inst_pc held stable until dec_ready; dec_ready -> FETCH (or HALT if halt pending).
REQ-023 Redirect in FETCH without ack: target stored in pending register, request completes, returned data discarded, pc<=target, stay FETCH with new address.
REQ-024 Redirect in FETCH with ack same cycle: data discarded, pc<=redirect_pc, stay FETCH.
REQ-025 Redirect in ISSUE without dec_ready: inst killed (inst_valid=0 next cycle), pc<=redirect_pc, -> FETCH.
REQ-026 Redirect in ISSUE with dec_ready: inst accepted, pc<=redirect_pc, -> FETCH.
REQ-027 Multiple redirects before completion: latest target SHALL win.
REQ-028 Redirect in IDLE or HALT SHALL be ignored.
REQ-029 Target with [1:0]!=0: pc<=TRAP_VEC instead, misalign<=1 until rst.
REQ-030 halt_req SHALL set a sticky halt-pending flag; FETCH finishes and issues its instruction; HALT entered on ISSUE handshake.
REQ-031 Halt pending with redirect: redirect discards fetch per REQ-023/024; HALT entered at next ISSUE handshake.
REQ-032 HALT: imem_req=0, inst_valid=0, pc held; exit only via rst; start ignored.
REQ-033 busy SHALL be 1 in FETCH and ISSUE, 0 otherwise.

Reset
REQ-034 rst SHALL take priority over all inputs, including mid-FETCH (outstanding request abandoned, late ack ignored).
REQ-035 Reset values: state=IDLE, pc=RESET_PC, imem_req=0, inst_valid=0, inst=0, inst_pc=0, misalign=0, busy=0, pending flags cleared.

Verification
REQ-036 rst, start, ack after 2 cycles with rdata=32'h00500093, dec_ready=1 -> inst_valid 1 cycle after ack, inst_pc=0x000, pc=0x004.
REQ-037 pc=0x3FC fetch+issue -> pc=0x000, no misalign.
REQ-038 redirect to 0x040 in FETCH two cycles before ack -> imem_addr unchanged until ack, data discarded, next imem_addr=0x040, no inst_valid for discarded word.
REQ-039 ISSUE with dec_ready=0 for 3 cycles then redirect to 0x080 -> inst stable 3 cycles, inst_valid drops, imem_addr=0x080.
REQ-040 redirect_pc=0x042 -> pc=0x3F0, misalign=1 persisting until rst.
REQ-041 halt_req in FETCH -> current inst issued, then HALT, imem_req=0, busy=0; start ignored; rst returns to IDLE, pc=0x000.
